rr_req_arbiter: RTL and testbench

//   Registered round-robin arbiter for 8 request lines. Produces the one-hot

---
 rtl/rr_req_arbiter_if.sv | 10 +
 rtl/rr_req_arbiter.sv | 90 +++++++++
 tb/tb_rr_req_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rr_req_arbiter_if.sv
// rr_req_arbiter_if: request/done inputs and one-hot grant outputs of the round-robin arbiter
interface rr_req_arbiter_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic       grant_valid;
   logic       timeout;
   modport master (output req, done, input grant, grant_valid, timeout);
   modport slave  (input req, done, output grant, grant_valid, timeout);
endinterface

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: registered 8-way round-robin arbiter with hold timeout, one-hot grant
module rr_req_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input logic            clk,
   input logic            rst_n,
   rr_req_arbiter_if.slave bus
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t           state;
   logic [7:0]       grant;
   logic             grant_valid;
   logic             timeout;
   logic [2:0]       ptr;
   logic [CNT_W-1:0] hold_cnt;
   logic [2:0]       g;
   logic             drop;
   logic             hold_exp;
   logic             fin;
   logic [7:0]       cand;
   logic [7:0]       win;

   // first set bit of c scanning upward from p with wrap; lowest offset wins
   function automatic logic [7:0] pick(input logic [7:0] c, input logic [2:0] p);
      logic [2:0] k;
      pick = '0;
      for (int i = 7; i >= 0; i--) begin
         k = p + 3'(i);
         if (c[k]) begin
            pick    = '0;
            pick[k] = 1'b1;
         end
      end
   endfunction

   // index of the current grantee, decoded from the one-hot grant
   always_comb begin
      g = '0;
      for (int i = 0; i < 8; i++) if (grant[i]) g = 3'(i);
   end

   // end-of-grant conditions and the back-to-back successor
   always_comb begin
      drop     = ~|(bus.req & grant);
      hold_exp = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
      fin      = bus.done | drop | hold_exp;
      cand     = bus.req & ~grant;
      win      = pick(cand, g + 3'd1);
   end

   // arbitration FSM; all outputs registered so grant only moves at edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
         ptr         <= '0;
         hold_cnt    <= '0;
      end else begin
         timeout <= 1'b0;
         if (state == IDLE) begin
            if (|bus.req) begin
               grant       <= pick(bus.req, ptr);
               grant_valid <= 1'b1;
               hold_cnt    <= '0;
               state       <= GRANT;
            end
         end else if (fin) begin
            ptr      <= g + 3'd1;
            hold_cnt <= '0;
            timeout  <= hold_exp & ~bus.done & ~drop;
            if (|cand) begin
               grant <= win;
            end else begin
               grant       <= '0;
               grant_valid <= 1'b0;
               state       <= IDLE;
            end
         end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.grant       = grant;
   assign bus.grant_valid = grant_valid;
   assign bus.timeout     = timeout;
endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb_rr_req_arbiter: directed stimulus with a cycle-level reference model and literal checks
module tb_rr_req_arbiter;
   localparam int MAX_HOLD = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   rr_req_arbiter_if bus();

   rr_req_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: who holds the grant, since which cycle, and where the search starts
   int   m_owner = -1;
   int   m_start = 0;
   int   m_ptr   = 0;
   int   m_cyc   = 0;
   bit   m_to    = 1'b0;

   function automatic int search(input logic [7:0] v, input int p);
      for (int k = 0; k < 8; k++) if (v[(p + k) % 8]) return (p + k) % 8;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_ptr   = 0;
         m_to    = 1'b0;
      end else begin
         logic [7:0] rest;
         bit by_done, by_drop, by_time;
         m_cyc++;
         m_to = 1'b0;
         if (m_owner < 0) begin
            if (bus.req != 8'h00) begin
               m_owner = search(bus.req, m_ptr);
               m_start = m_cyc;
            end
         end else begin
            by_done = bus.done;
            by_drop = !bus.req[m_owner];
            by_time = (MAX_HOLD != 0) && (m_cyc - m_start == MAX_HOLD);
            if (by_done || by_drop || by_time) begin
               m_to    = by_time && !by_done && !by_drop;
               m_ptr   = (m_owner + 1) % 8;
               rest    = bus.req;
               rest[m_owner] = 1'b0;
               m_owner = search(rest, m_ptr);
               m_start = m_cyc;
            end
         end
      end
   end

   // every cycle: DUT outputs against the model, plus structural invariants
   always @(posedge clk) begin
      logic [7:0] eg;
      #1;
      eg = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
      chk("model_grant", bus.grant, eg);
      chk("model_valid", {7'd0, bus.grant_valid}, {7'd0, m_owner >= 0});
      chk("model_timeout", {7'd0, bus.timeout}, {7'd0, m_to});
      chk("onehot", {7'd0, $onehot0(bus.grant)}, 8'h01);
      chk("valid_eq_or", {7'd0, bus.grant_valid}, {7'd0, |bus.grant});
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      bus.req  = 8'hFF;
      bus.done = 1'b0;
      // 1: reset held with all requests, then first grant one edge after release
      tick();
      tick();
      chk("rst_grant", bus.grant, 8'h00);
      chk("rst_valid", {7'd0, bus.grant_valid}, 8'h00);
      rst_n = 1'b1;
      tick();
      chk("first_grant", bus.grant, 8'h01);
      chk("first_valid", {7'd0, bus.grant_valid}, 8'h01);
      // 2: alternating 0/7 back-to-back on done pulses
      bus.req  = 8'h81;
      bus.done = 1'b1;
      tick();
      chk("alt1", bus.grant, 8'h80);
      tick();
      chk("alt2", bus.grant, 8'h01);
      tick();
      chk("alt3", bus.grant, 8'h80);
      // 3: pointer wraps from 7 to 0 and picks 4
      bus.req = 8'h90;
      tick();
      chk("wrap", bus.grant, 8'h10);
      tick();
      chk("after_wrap", bus.grant, 8'h80);
      bus.done = 1'b0;
      // 4: single requester held past MAX_HOLD
      bus.req = 8'h04;
      tick();
      chk("hold_start", bus.grant, 8'h04);
      for (int i = 0; i < MAX_HOLD - 1; i++) begin
         tick();
         chk("hold", bus.grant, 8'h04);
         chk("hold_to", {7'd0, bus.timeout}, 8'h00);
      end
      tick();
      chk("to_pulse", {7'd0, bus.timeout}, 8'h01);
      chk("to_idle", bus.grant, 8'h00);
      tick();
      chk("to_regrant", bus.grant, 8'h04);
      chk("to_once", {7'd0, bus.timeout}, 8'h00);
      // 5: request drop ends the grant without a timeout
      bus.req = 8'h02;
      tick();
      chk("g02", bus.grant, 8'h02);
      bus.req = 8'h00;
      tick();
      chk("drop_grant", bus.grant, 8'h00);
      chk("drop_valid", {7'd0, bus.grant_valid}, 8'h00);
      chk("drop_to", {7'd0, bus.timeout}, 8'h00);
      bus.done = 1'b1;
      tick();
      chk("idle_done", bus.grant, 8'h00);
      bus.done = 1'b0;
      // 5b: done on the expiry edge suppresses the timeout pulse
      bus.req = 8'h02;
      tick();
      chk("g02b", bus.grant, 8'h02);
      for (int i = 0; i < MAX_HOLD - 1; i++) tick();
      bus.done = 1'b1;
      tick();
      chk("done_vs_to", {7'd0, bus.timeout}, 8'h00);
      chk("done_vs_to_g", bus.grant, 8'h00);
      bus.done = 1'b0;
      // 6: asynchronous reset mid-grant, then pointer starts from 0 again
      bus.req = 8'h01;
      tick();
      chk("pre_rst", bus.grant, 8'h01);
      #1 rst_n = 1'b0;
      #1;
      chk("async_grant", bus.grant, 8'h00);
      chk("async_valid", {7'd0, bus.grant_valid}, 8'h00);
      tick();
      bus.req = 8'h08;
      rst_n = 1'b1;
      tick();
      chk("post_rst", bus.grant, 8'h08);
      bus.req = 8'h09;
      bus.done = 1'b1;
      tick();
      chk("post_rst_next", bus.grant, 8'h01);
      bus.done = 1'b0;
      bus.req = 8'h00;
      tick();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
